// File: rtl/m6809_reset_seq.sv
// Reset and halt sequencer for the 6809 SoC: synchronises the board reset, releases the
// peripheral domains one by one, then the CPU, and runs the BA/BS halt handshake.
module m6809_reset_seq #(
  parameter int NUM_DOMAINS    = 2,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGGER_CYCLES = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int HALT_TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   sw_rst_req,
  input  logic                   halt_req,
  input  logic                   cpu_ba,
  input  logic                   cpu_bs,
  output logic [NUM_DOMAINS-1:0] dom_reset_b,
  output logic                   cpu_reset_b,
  output logic                   cpu_halt_b,
  output logic                   halted,
  output logic                   por_done,
  output logic                   halt_err
);

  localparam int FINAL_COUNT = HOLD_CYCLES + NUM_DOMAINS * STAGGER_CYCLES;
  localparam int CW = $clog2(FINAL_COUNT + 1);
  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] FINAL_C   = CW'(FINAL_COUNT);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(HALT_TIMEOUT);

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_RELEASE   = 3'd1,
    ST_RUN       = 3'd2,
    ST_HALT_WAIT = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rst_sync_s;
  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [TW-1:0]          tcnt_r, tcnt_s, tinc_s;
  logic [NUM_DOMAINS-1:0] dom_r, dom_s;
  logic                   cpu_rst_r, cpu_rst_s;
  logic                   halt_b_r, halt_b_s;
  logic                   halted_r, halted_s;
  logic                   por_r, por_s;
  logic                   err_r, err_s;
  logic                   ack_s;

  assign rst_sync_s = sync_r[SYNC_STAGES-1];
  assign ack_s      = cpu_ba & cpu_bs;
  assign tinc_s     = (tcnt_r == TIMEOUT_C) ? tcnt_r : tcnt_r + TW'(1);

  // Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES edges
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) sync_r <= '0;
    else          sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
  end

  // State, counters and registered outputs; held at reset values until rst_sync rises
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= ST_ASSERT; cnt_r <= '0; tcnt_r <= '0; dom_r <= '0;
      cpu_rst_r <= 1'b0; halt_b_r <= 1'b1; halted_r <= 1'b0; por_r <= 1'b0; err_r <= 1'b0;
    end else if (!rst_sync_s) begin
      state_r <= ST_ASSERT; cnt_r <= '0; tcnt_r <= '0; dom_r <= '0;
      cpu_rst_r <= 1'b0; halt_b_r <= 1'b1; halted_r <= 1'b0; por_r <= 1'b0; err_r <= 1'b0;
    end else begin
      state_r <= state_s; cnt_r <= cnt_s; tcnt_r <= tcnt_s; dom_r <= dom_s;
      cpu_rst_r <= cpu_rst_s; halt_b_r <= halt_b_s; halted_r <= halted_s;
      por_r <= por_s; err_r <= err_s;
    end
  end

  // Next-state and counter logic; software reset only acts once the sequence is done
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    tcnt_s  = tcnt_r;
    case (state_r)
      ST_ASSERT: begin
        cnt_s = cnt_r + CW'(1);
        if (cnt_r == HOLD_C) state_s = ST_RELEASE;
        else                 state_s = ST_ASSERT;
      end
      ST_RELEASE: begin
        if (cnt_r == FINAL_C) state_s = ST_RUN;
        else                  cnt_s = cnt_r + CW'(1);
      end
      ST_RUN: begin
        if (sw_rst_req) begin
          state_s = ST_ASSERT; cnt_s = '0;
        end else if (halt_req) begin
          state_s = ST_HALT_WAIT; tcnt_s = '0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_HALT_WAIT: begin
        if (sw_rst_req) begin
          state_s = ST_ASSERT; cnt_s = '0;
        end else if (ack_s) begin
          state_s = ST_HALTED;
        end else if (!halt_req) begin
          state_s = ST_RUN;
        end else begin
          tcnt_s = tinc_s;
        end
      end
      ST_HALTED: begin
        if (sw_rst_req) begin
          state_s = ST_ASSERT; cnt_s = '0;
        end else if (!halt_req) begin
          state_s = ST_RUN;
        end else if (!ack_s) begin
          state_s = ST_HALT_WAIT; tcnt_s = '0;
        end else begin
          state_s = ST_HALTED;
        end
      end
      default: begin
        state_s = ST_ASSERT; cnt_s = '0; tcnt_s = '0;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    dom_s     = dom_r;
    cpu_rst_s = cpu_rst_r;
    halt_b_s  = halt_b_r;
    halted_s  = halted_r;
    por_s     = por_r;
    err_s     = err_r;
    case (state_r)
      ST_ASSERT: begin
        if (cnt_r == HOLD_C) dom_s[0] = 1'b1;
        else                 dom_s[0] = dom_r[0];
      end
      ST_RELEASE: begin
        for (int k = 0; k < NUM_DOMAINS; k++) begin
          if (cnt_r == CW'(HOLD_CYCLES + k * STAGGER_CYCLES)) dom_s[k] = 1'b1;
          else                                               dom_s[k] = dom_r[k];
        end
        if (cnt_r == FINAL_C) begin
          cpu_rst_s = 1'b1; por_s = 1'b1;
        end else begin
          cpu_rst_s = cpu_rst_r; por_s = por_r;
        end
      end
      ST_RUN: begin
        if (sw_rst_req) begin
          dom_s = '0; cpu_rst_s = 1'b0; halt_b_s = 1'b1; halted_s = 1'b0; por_s = 1'b0; err_s = 1'b0;
        end else if (halt_req) begin
          halt_b_s = 1'b0;
        end else begin
          halt_b_s = 1'b1;
        end
      end
      ST_HALT_WAIT: begin
        if (sw_rst_req) begin
          dom_s = '0; cpu_rst_s = 1'b0; halt_b_s = 1'b1; halted_s = 1'b0; por_s = 1'b0; err_s = 1'b0;
        end else if (ack_s) begin
          halted_s = 1'b1;
        end else if (!halt_req) begin
          halt_b_s = 1'b1;
        end else if (tinc_s == TIMEOUT_C) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
      end
      ST_HALTED: begin
        if (sw_rst_req) begin
          dom_s = '0; cpu_rst_s = 1'b0; halt_b_s = 1'b1; halted_s = 1'b0; por_s = 1'b0; err_s = 1'b0;
        end else if (!halt_req) begin
          halt_b_s = 1'b1; halted_s = 1'b0;
        end else if (!ack_s) begin
          halted_s = 1'b0;
        end else begin
          halted_s = 1'b1;
        end
      end
      default: begin
        dom_s = '0; cpu_rst_s = 1'b0; halt_b_s = 1'b1; halted_s = 1'b0; por_s = 1'b0; err_s = 1'b0;
      end
    endcase
  end

  assign dom_reset_b = dom_r;
  assign cpu_reset_b = cpu_rst_r;
  assign cpu_halt_b  = halt_b_r;
  assign halted      = halted_r;
  assign por_done    = por_r;
  assign halt_err    = err_r;

endmodule

// File: doc/m6809_reset_seq.md
# m6809_reset_seq

Parametrised reset and halt sequencer for the 6809 SoC. It turns the board-level asynchronous reset into a synchronised, staggered release of N peripheral reset domains followed by the CPU. It also accepts a software reset request and runs a halt request/acknowledge handshake with the CPU using the 6809 BA/BS bus-status pins. It sits between the top-level reset_b/halt_b pins and m6809_integration's internal CPU and peripherals.

## Interface
Parameters:
- NUM_DOMAINS, 2: number of peripheral reset domains (>=1).
- HOLD_CYCLES, 8: cycles all resets stay asserted after the synchronised reset deasserts (>=1).
- STAGGER_CYCLES, 2: cycles between successive domain releases (>=1).
- SYNC_STAGES, 2: reset-deassertion synchroniser depth (>=2).
- HALT_TIMEOUT, 64: cycles allowed from halt assertion to BA/BS acknowledge (>=1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- sw_rst_req  in  1  single-cycle software reset request.
- halt_req  in  1  level halt request from debug or pin logic.
- cpu_ba  in  1  CPU bus-available status.
- cpu_bs  in  1  CPU bus-state status.
- dom_reset_b  out  NUM_DOMAINS  per-domain active-low resets.
- cpu_reset_b  out  1  CPU active-low reset.
- cpu_halt_b  out  1  CPU active-low halt.
- halted  out  1  CPU is acknowledged halted.
- por_done  out  1  reset sequence complete.
- halt_err  out  1  sticky: halt acknowledge timed out.

## Operation
- Synchroniser: a SYNC_STAGES flop chain of 1s gives rst_sync. Assertion is asynchronous; deassertion is synchronous. The FSM and counters are reset by rst_sync low.
- Reset values (reset_b low or rst_sync low): dom_reset_b = all 0, cpu_reset_b = 0, cpu_halt_b = 1, halted = 0, por_done = 0, halt_err = 0, state ASSERT, counter 0.
- ASSERT:
  - Counter increments every cycle.
  - At count HOLD_CYCLES, release dom_reset_b[0] and go to RELEASE.
- RELEASE:
  - dom_reset_b[k] goes high at count HOLD_CYCLES + k*STAGGER_CYCLES.
  - cpu_reset_b and por_done go high together at count HOLD_CYCLES + NUM_DOMAINS*STAGGER_CYCLES; state becomes RUN.
  - Released domains stay released.
  - The counter is wide enough for the final count with no wrap.
- RUN: if halt_req = 1, drive cpu_halt_b = 0 next cycle, clear the timeout counter, go to HALT_WAIT.
- HALT_WAIT:
  - If cpu_ba & cpu_bs: halted = 1, go to HALTED.
  - Else if halt_req = 0: cpu_halt_b = 1, go to RUN.
  - If the timeout counter reaches HALT_TIMEOUT: set halt_err (sticky) and keep waiting. The timeout counter saturates.
- HALTED:
  - If halt_req = 0: cpu_halt_b = 1 and halted = 0 next cycle, go to RUN.
  - If cpu_ba or cpu_bs drops while halt_req = 1: halted = 0, go to HALT_WAIT, restart the timeout counter.
- sw_rst_req in RUN, HALT_WAIT or HALTED:
  - Next cycle: all dom_reset_b, cpu_reset_b and por_done go to 0; cpu_halt_b = 1; halted = 0; halt_err cleared; counter 0; state ASSERT. The full sequence then reruns.
  - Ignored in ASSERT and RELEASE.
- Simultaneous sw_rst_req and halt_req: sw_rst_req wins.

## Timing
- t0 is the first rising edge with rst_sync high. reset_b rising to t0 takes SYNC_STAGES edges.
- All outputs are registered: one cycle from the deciding input to the output change.
- Defaults: dom0 releases at t0+8, dom1 at t0+10, cpu_reset_b and por_done at t0+12.
- Halt handshake: halt_req sampled high at edge n gives cpu_halt_b low after edge n. halted rises one cycle after the edge on which BA & BS are sampled high.
- reset_b low at any time, including mid-sequence or while halted, forces every output to its reset value immediately (asynchronously).

## Test plan
- Power-on, defaults, reset_b low for 100 ns then high -> outputs held at reset values; dom_reset_b = 01 at t0+8, 11 at t0+10; cpu_reset_b = 1 and por_done = 1 at t0+12.
- Halt ack: in RUN, halt_req = 1; drive BA = BS = 1 three cycles after cpu_halt_b falls -> halted = 1 one cycle later. halt_req = 0 -> cpu_halt_b = 1 and halted = 0 next cycle.
- Halt timeout: HALT_TIMEOUT = 4, BA/BS held 0 -> halt_err = 1 after 4 cycles and stays set. A later sw_rst_req clears it.
- sw_rst_req while HALTED -> all resets reasserted next cycle; cpu_halt_b = 1; full staggered release repeats with the same offsets.
- reset_b pulsed low mid-RELEASE (after dom0 released) -> dom_reset_b = 00 asynchronously; the sequence restarts from t0.
- NUM_DOMAINS = 4, STAGGER_CYCLES = 3, HOLD_CYCLES = 1 -> domain releases at t0+1, 4, 7, 10; cpu_reset_b at t0+13.
